// File: rtl/pingpong_pkg.sv
// Shared constants, FSM state type and range helper for the ball/paddle
// coordinate link.
package pingpong_pkg;
    localparam int COORD_W = 11;
    localparam logic [COORD_W-1:0] X_MAX = 11'd639;
    localparam logic [COORD_W-1:0] Y_MAX = 11'd479;
    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int FRAME_LEN = 10;

    localparam logic [COORD_W-1:0] RST_XBALL = 11'd320;
    localparam logic [COORD_W-1:0] RST_YBALL = 11'd240;
    localparam logic [COORD_W-1:0] RST_XPAT  = 11'd16;
    localparam logic [COORD_W-1:0] RST_YPAT  = 11'd240;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CSUM    = 2'd2
    } frame_state_t;

    // A value is lo plus hi[2:0]; any of hi[7:3] set is out of range.
    function automatic logic coord_in_range(input logic [7:0] lo, input logic [7:0] hi,
                                            input logic [COORD_W-1:0] max);
        return (hi[7:3] == 5'd0) && ({hi[2:0], lo} <= max);
    endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, framing check.
// Handshake: byte_valid / byte_err are single-cycle strobes with no back-pressure;
// byte_data is stable from the byte_valid cycle until the next byte completes.
module uart_rx_byte
    import pingpong_pkg::*;
#(
    parameter int BIT_CYC = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err,
    output logic [1:0] dbg_state
);
    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYC / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    warm;
    logic          idle_seen;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          start_edge;

    // A line held low across reset release must go high before a start counts.
    assign start_edge = idle_seen && rx_prev && !rx_sync;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            warm       <= 2'd0;
            idle_seen  <= 1'b0;
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'd0;
            byte_data  <= 8'd0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            rx_meta    <= rxd;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            if (warm != 2'd3) warm <= warm + 2'd1;
            if (warm == 2'd3 && rx_sync) idle_seen <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Stop-bit mid sample; re-arming here allows zero-idle back-to-back bytes.
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            byte_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/coord_frame_rx.sv
// Coordinate frame receiver: assembles 10-byte frames from the MCU link and
// atomically updates the ball/paddle coordinate bus after header/checksum/range checks.
module coord_frame_rx
    import pingpong_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 115200,
    parameter int GAP_CYC = 20 * (CLK_HZ / BAUD)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rxd,
    output logic [COORD_W-1:0] xball,
    output logic [COORD_W-1:0] yball,
    output logic [COORD_W-1:0] xpat,
    output logic [COORD_W-1:0] ypat,
    output logic               frame_ok,
    output logic               frame_err,
    output logic               led,
    output logic [3:0]         dbg_state
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_M1 = GW'(GAP_CYC - 1);

    logic [7:0]   byte_data;
    logic         byte_valid, byte_err;
    logic [1:0]   byte_dbg;
    frame_state_t state;
    logic [2:0]   idx;
    logic [7:0]   shadow [8];
    logic [7:0]   csum;
    logic [GW-1:0] gap;
    logic         sum_ok, range_ok, gap_hit;

    uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_byte (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_err  (byte_err),
        .dbg_state (byte_dbg)
    );

    assign sum_ok   = (byte_data == csum);
    assign range_ok = coord_in_range(shadow[0], shadow[1], X_MAX)
                   && coord_in_range(shadow[2], shadow[3], Y_MAX)
                   && coord_in_range(shadow[4], shadow[5], X_MAX)
                   && coord_in_range(shadow[6], shadow[7], Y_MAX);
    assign gap_hit   = (gap == GAP_M1);
    assign dbg_state = {byte_dbg, state};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            idx       <= 3'd0;
            csum      <= 8'd0;
            gap       <= '0;
            for (int i = 0; i < 8; i++) shadow[i] <= 8'd0;
            xball     <= RST_XBALL;
            yball     <= RST_YBALL;
            xpat      <= RST_XPAT;
            ypat      <= RST_YPAT;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            led       <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                HUNT: begin
                    if (byte_valid && byte_data == FRAME_HDR) begin
                        state <= PAYLOAD;
                        idx   <= 3'd0;
                        csum  <= 8'd0;
                        gap   <= '0;
                    end
                end
                PAYLOAD, CSUM: begin
                    if (byte_err || (!byte_valid && gap_hit)) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                    end else if (byte_valid) begin
                        gap <= '0;
                        if (state == PAYLOAD) begin
                            shadow[idx] <= byte_data;
                            csum        <= csum ^ byte_data;
                            idx         <= idx + 3'd1;
                            if (idx == 3'd7) state <= CSUM;
                        end else begin
                            state <= HUNT;
                            if (sum_ok && range_ok) begin
                                xball    <= {shadow[1][2:0], shadow[0]};
                                yball    <= {shadow[3][2:0], shadow[2]};
                                xpat     <= {shadow[5][2:0], shadow[4]};
                                ypat     <= {shadow[7][2:0], shadow[6]};
                                frame_ok <= 1'b1;
                                led      <= ~led;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_coord_frame_rx.sv
// Directed bench for coord_frame_rx: serial frames in, scoreboard of expected
// frame_ok/frame_err events with the coordinate bus they must carry.
module tb_coord_frame_rx;
    localparam int CLK_HZ  = 1_843_200;
    localparam int BAUD    = 115200;
    localparam int BIT     = CLK_HZ / BAUD;
    localparam int GAP     = 20 * BIT;
    localparam int W       = 46;
    localparam logic [43:0] RST_BUS = {11'd320, 11'd240, 11'd16, 11'd240};

    logic        clk, reset, rxd;
    logic [10:0] xball, yball, xpat, ypat;
    logic        frame_ok, frame_err, led;
    logic [3:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    logic [43:0]  model_bus;
    logic         exp_led;
    logic [43:0]  prev_bus;
    logic         prev_ok;
    int           n_cmp, n_mis;

    coord_frame_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_CYC(GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .xball    (xball),
        .yball    (yball),
        .xpat     (xpat),
        .ypat     (ypat),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .led      (led),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
        if (!stop) repeat (BIT) @(negedge clk);
    endtask

    function automatic logic [63:0] mk_payload(input logic [10:0] x, input logic [10:0] y,
                                               input logic [10:0] xp, input logic [10:0] yp);
        return {5'd0, yp[10:8], yp[7:0], 5'd0, xp[10:8], xp[7:0],
                5'd0, y[10:8], y[7:0], 5'd0, x[10:8], x[7:0]};
    endfunction

    function automatic logic [7:0] xsum(input logic [63:0] p);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 8; i++) s = s ^ p[8*i +: 8];
        return s;
    endfunction

    task automatic send_frame(input logic [63:0] p, input logic [7:0] cs);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(p[8*i +: 8], 1'b1);
        send_byte(cs, 1'b1);
    endtask

    task automatic expect_ok(input logic [43:0] bus);
        model_bus = bus;
        exp_q.push_back({2'b10, bus});
    endtask

    task automatic expect_err();
        exp_q.push_back({2'b01, model_bus});
    endtask

    task automatic settle(input string tag);
        repeat (4 * BIT) @(negedge clk);
        check(tag, W'(exp_q.size()), W'(0));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [43:0]  cur;
        logic [W-1:0] expv;
        if (!reset) begin
            exp_led = 1'b0;
            prev_ok = 1'b0;
        end else begin
            cur = {xball, yball, xpat, ypat};
            if (frame_ok || frame_err) begin
                check("pulse_excl", W'(frame_ok & frame_err), W'(0));
                expv = (exp_q.size() == 0) ? '0 : exp_q.pop_front();
                check("frame_event", {frame_ok, frame_err, cur}, expv);
                if (frame_ok) exp_led = ~exp_led;
                check("led", W'(led), W'(exp_led));
            end
            if (prev_ok && cur !== prev_bus) check("bus_edge_ok", W'(frame_ok), W'(1));
            prev_bus = cur;
            prev_ok  = 1'b1;
        end
    end

    initial begin
        logic [63:0] p;
        n_cmp = 0;
        n_mis = 0;
        exp_led = 1'b0;
        prev_ok = 1'b0;
        prev_bus = '0;
        model_bus = RST_BUS;
        rxd = 1'b1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        check("reset_bus", {2'b00, xball, yball, xpat, ypat}, {2'b00, RST_BUS});
        check("reset_led", W'(led), W'(0));
        check("reset_pulses", W'({frame_ok, frame_err}), W'(0));
        check("reset_state", W'(dbg_state), W'(0));

        // valid frame with the reference checksum
        p = 64'h00C8_0064_00F0_0140;
        expect_ok({11'd320, 11'd240, 11'd100, 11'd200});
        send_frame(p, 8'h1D);
        settle("pending_good");
        check("led_after_good", W'(led), W'(1));

        // bad checksum
        expect_err();
        send_frame(p, 8'h1C);
        settle("pending_badcsum");

        // xball 640 out of range, then 639/479 boundary accepted
        p = mk_payload(11'd640, 11'd240, 11'd100, 11'd200);
        expect_err();
        send_frame(p, xsum(p));
        settle("pending_x640");
        p = mk_payload(11'd639, 11'd240, 11'd100, 11'd479);
        expect_ok({11'd639, 11'd240, 11'd100, 11'd479});
        send_frame(p, xsum(p));
        settle("pending_x639");
        check("led_after_639", W'(led), W'(0));

        // ypat 480 and a stray hi bit are range errors
        p = mk_payload(11'd5, 11'd6, 11'd7, 11'd480);
        expect_err();
        send_frame(p, xsum(p));
        settle("pending_y480");
        p = mk_payload(11'd5, 11'd6, 11'd7, 11'd8) | 64'h0000_0800_0000_0000;
        expect_err();
        send_frame(p, xsum(p));
        settle("pending_hibit");

        // 0xA5 as payload data, no resync
        p = mk_payload(11'h0A5, 11'h0A5, 11'd1, 11'd2);
        expect_ok({11'h0A5, 11'h0A5, 11'd1, 11'd2});
        send_frame(p, xsum(p));
        settle("pending_a5data");

        // framing error on payload byte 3, then a clean frame
        p = mk_payload(11'd10, 11'd20, 11'd30, 11'd40);
        expect_err();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(p[8*i +: 8], 1'b1);
        send_byte(p[31:24], 1'b0);
        settle("pending_stop0");
        expect_ok({11'd10, 11'd20, 11'd30, 11'd40});
        send_frame(p, xsum(p));
        settle("pending_after_stop0");

        // inter-byte gap timeout, trailing bytes ignored in HUNT
        p = mk_payload(11'd600, 11'd400, 11'd50, 11'd60);
        expect_err();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(p[8*i +: 8], 1'b1);
        repeat (GAP + BIT) @(negedge clk);
        check("gap_timeout", W'(exp_q.size()), W'(0));
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        settle("pending_trailing");

        // reset in the middle of byte 6, line still low at release
        p = mk_payload(11'd111, 11'd222, 11'd333, 11'd444);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(p[8*i +: 8], 1'b1);
        rxd = 1'b0;
        repeat (5 * BIT) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        model_bus = RST_BUS;
        check("midreset_bus", {2'b00, xball, yball, xpat, ypat}, {2'b00, RST_BUS});
        check("midreset_led", W'(led), W'(0));
        p = mk_payload(11'd1, 11'd2, 11'd3, 11'd4);
        expect_ok({11'd1, 11'd2, 11'd3, 11'd4});
        send_frame(p, xsum(p));
        settle("pending_after_reset");
        check("final_bus", {2'b00, xball, yball, xpat, ypat}, {2'b00, model_bus});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
